// File: rtl/sram_arbiter_if.sv
// Requester handshakes, read-back data and SRAM pin bundle for sram_arbiter.
// The slave modport is the arbiter's view; master is the requester/board side.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_done;

  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic              aux_done;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_wdata_oe;
  logic [DATA_W-1:0] sram_rdata;
  logic              Mem_CE;
  logic              Mem_UB;
  logic              Mem_LB;
  logic              Mem_OE;
  logic              Mem_WE;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    input  sram_rdata,
    output cpu_done, aux_done, rdata, busy,
    output sram_addr, sram_wdata, sram_wdata_oe,
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output aux_req, aux_we, aux_addr, aux_wdata,
    output sram_rdata,
    input  cpu_done, aux_done, rdata, busy,
    input  sram_addr, sram_wdata, sram_wdata_oe,
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter for one asynchronous SRAM: fixed-length strobe window, then a
// one-cycle bus turnaround in which the owner's done pulses.
module sram_arbiter #(
  parameter int unsigned ADDR_W        = 20,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input logic           Clk,
  input logic           Reset,
  sram_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(ACCESS_CYCLES - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAccess  = 2'd1;
  localparam logic [1:0] StRecover = 2'd2;

  // Owner encoding: 0 = cpu, 1 = aux.
  localparam logic OwnCpu = 1'b0;
  localparam logic OwnAux = 1'b1;

  logic [1:0]        state;
  logic [CNT_W-1:0]  counter;
  logic              last_owner;
  logic              owner;
  logic              op_we;
  logic [DATA_W-1:0] rdata_r;
  logic [ADDR_W-1:0] sram_addr_r;
  logic [DATA_W-1:0] sram_wdata_r;

  logic pick_aux;
  logic in_access;

  // Aux wins when alone, or on a tie when cpu was served last.
  always_comb begin
    pick_aux = bus.aux_req && (!bus.cpu_req || (last_owner == OwnCpu));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= StIdle;
      counter      <= '0;
      last_owner   <= OwnAux;
      owner        <= OwnCpu;
      op_we        <= 1'b0;
      rdata_r      <= '0;
      sram_addr_r  <= '0;
      sram_wdata_r <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (bus.cpu_req || bus.aux_req) begin
            owner        <= pick_aux ? OwnAux : OwnCpu;
            op_we        <= pick_aux ? bus.aux_we : bus.cpu_we;
            sram_addr_r  <= pick_aux ? bus.aux_addr : bus.cpu_addr;
            sram_wdata_r <= pick_aux ? bus.aux_wdata : bus.cpu_wdata;
            counter      <= '0;
            state        <= StAccess;
          end
        end
        StAccess: begin
          counter <= counter + 1'b1;
          if (counter == LastCnt) begin
            if (!op_we) begin
              rdata_r <= bus.sram_rdata;
            end
            state <= StRecover;
          end
        end
        StRecover: begin
          last_owner <= owner;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Pin decode uses only registered state so the strobes cannot glitch.
  always_comb begin
    in_access         = (state == StAccess);
    bus.Mem_CE        = !in_access;
    bus.Mem_UB        = !in_access;
    bus.Mem_LB        = !in_access;
    bus.Mem_OE        = !(in_access && !op_we);
    bus.Mem_WE        = !(in_access && op_we);
    bus.sram_wdata_oe = in_access && op_we;
    bus.cpu_done      = (state == StRecover) && (owner == OwnCpu);
    bus.aux_done      = (state == StRecover) && (owner == OwnAux);
    bus.busy          = (state != StIdle);
    bus.rdata         = rdata_r;
    bus.sram_addr     = sram_addr_r;
    bus.sram_wdata    = sram_wdata_r;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: cycle-by-cycle vector table for single accesses,
// plus hand-written contention, mid-access reset and ACCESS_CYCLES=3 sequences.
module tb_sram_arbiter;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();
  sram_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus3 ();

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(2)) u_dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(3)) u_dut3 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus3)
  );

  // Read-only SRAM model: one known word, everything else an address pattern.
  function automatic logic [15:0] model_rd(input logic [19:0] a);
    if (a == 20'h00010) return 16'hBEEF;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  assign bus.sram_rdata  = model_rd(bus.sram_addr);
  assign bus3.sram_rdata = model_rd(bus3.sram_addr);

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic        c_req;
    logic        c_we;
    logic [19:0] c_addr;
    logic [15:0] c_wdata;
    logic        a_req;
    logic        a_we;
    logic [19:0] a_addr;
    logic [15:0] a_wdata;
    logic        e_busy;
    logic        e_ce;
    logic        e_oe;
    logic        e_we;
    logic        e_doe;
    logic        e_cdone;
    logic        e_adone;
    logic [15:0] e_rdata;
    logic [19:0] e_saddr;
    logic [15:0] e_swdata;
  } vec_t;

  vec_t vecs[8];

  // Steps until the selected port's done, counting cycles with Mem_CE low.
  task automatic wait_done(input bit use3, input bit want_aux, output int steps,
                           output int ce_low);
    steps  = -1;
    ce_low = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if ((use3 ? bus3.Mem_CE : bus.Mem_CE) == 1'b0) ce_low++;
      if (want_aux ? (use3 ? bus3.aux_done : bus.aux_done)
                   : (use3 ? bus3.cpu_done : bus.cpu_done)) begin
        steps = i;
        break;
      end
    end
  endtask

  initial begin
    int seen;
    int both;
    int dones;
    int steps;
    int ce_low;

    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.aux_req = 0; bus.aux_we = 0; bus.aux_addr = '0; bus.aux_wdata = '0;
    bus3.cpu_req = 0; bus3.cpu_we = 0; bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
    bus3.aux_req = 0; bus3.aux_we = 0; bus3.aux_addr = '0; bus3.aux_wdata = '0;

    //          c_req we addr       wdata     a_req we addr       wdata
    //          busy ce oe we doe cd ad rdata     saddr      swdata
    vecs[0] = '{1, 0, 20'h00010, 16'h7777, 0, 0, 20'h0, 16'h0,
                1, 0, 0, 1, 0, 0, 0, 16'h0000, 20'h00010, 16'h7777};
    vecs[1] = '{1, 0, 20'h00010, 16'h7777, 0, 0, 20'h0, 16'h0,
                1, 0, 0, 1, 0, 0, 0, 16'h0000, 20'h00010, 16'h7777};
    vecs[2] = '{1, 0, 20'h00010, 16'h7777, 0, 0, 20'h0, 16'h0,
                1, 1, 1, 1, 0, 1, 0, 16'hBEEF, 20'h00010, 16'h7777};
    vecs[3] = '{0, 0, 20'h00010, 16'h7777, 0, 0, 20'h0, 16'h0,
                0, 1, 1, 1, 0, 0, 0, 16'hBEEF, 20'h00010, 16'h7777};
    vecs[4] = '{0, 0, 20'h0, 16'h0, 1, 1, 20'h00020, 16'h1234,
                1, 0, 1, 0, 1, 0, 0, 16'hBEEF, 20'h00020, 16'h1234};
    vecs[5] = '{0, 0, 20'h0, 16'h0, 1, 1, 20'h00020, 16'h1234,
                1, 0, 1, 0, 1, 0, 0, 16'hBEEF, 20'h00020, 16'h1234};
    vecs[6] = '{0, 0, 20'h0, 16'h0, 1, 1, 20'h00020, 16'h1234,
                1, 1, 1, 1, 0, 0, 1, 16'hBEEF, 20'h00020, 16'h1234};
    vecs[7] = '{0, 0, 20'h0, 16'h0, 0, 0, 20'h0, 16'h0,
                0, 1, 1, 1, 0, 0, 0, 16'hBEEF, 20'h00020, 16'h1234};

    // Reset state.
    repeat (2) step();
    Reset = 1'b0;
    chk("rst.ce", bus.Mem_CE, 1);
    chk("rst.oe", bus.Mem_OE, 1);
    chk("rst.we", bus.Mem_WE, 1);
    chk("rst.busy", bus.busy, 0);
    chk("rst.rdata", bus.rdata, 16'h0000);
    chk("rst.dones", {bus.cpu_done, bus.aux_done}, 0);

    // CPU read then aux write, one vector per cycle.
    for (int i = 0; i < 8; i++) begin
      bus.cpu_req = vecs[i].c_req;   bus.cpu_we = vecs[i].c_we;
      bus.cpu_addr = vecs[i].c_addr; bus.cpu_wdata = vecs[i].c_wdata;
      bus.aux_req = vecs[i].a_req;   bus.aux_we = vecs[i].a_we;
      bus.aux_addr = vecs[i].a_addr; bus.aux_wdata = vecs[i].a_wdata;
      step();
      chk($sformatf("v%0d.busy", i), bus.busy, vecs[i].e_busy);
      chk($sformatf("v%0d.ce", i), bus.Mem_CE, vecs[i].e_ce);
      chk($sformatf("v%0d.ub", i), bus.Mem_UB, vecs[i].e_ce);
      chk($sformatf("v%0d.lb", i), bus.Mem_LB, vecs[i].e_ce);
      chk($sformatf("v%0d.oe", i), bus.Mem_OE, vecs[i].e_oe);
      chk($sformatf("v%0d.we", i), bus.Mem_WE, vecs[i].e_we);
      chk($sformatf("v%0d.doe", i), bus.sram_wdata_oe, vecs[i].e_doe);
      chk($sformatf("v%0d.cdone", i), bus.cpu_done, vecs[i].e_cdone);
      chk($sformatf("v%0d.adone", i), bus.aux_done, vecs[i].e_adone);
      chk($sformatf("v%0d.rdata", i), bus.rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d.saddr", i), bus.sram_addr, vecs[i].e_saddr);
      chk($sformatf("v%0d.swdata", i), bus.sram_wdata, vecs[i].e_swdata);
    end

    // Contention from reset: cpu first, then strict alternation every 4 cycles.
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 20'h00001;
    bus.aux_req = 1; bus.aux_we = 0; bus.aux_addr = 20'h00002;
    seen = 0;
    both = 0;
    for (int i = 1; i <= 30 && seen < 4; i++) begin
      step();
      if (bus.cpu_done && bus.aux_done) both++;
      if (bus.cpu_done || bus.aux_done) begin
        chk($sformatf("cont%0d.owner", seen), bus.aux_done, (seen % 2));
        chk($sformatf("cont%0d.cycle", seen), i, 3 + 4 * seen);
        chk($sformatf("cont%0d.rdata", seen), bus.rdata,
            (seen % 2) ? 16'h5A58 : 16'h5A5B);
        seen++;
        if (seen == 4) begin
          bus.cpu_req = 0;
          bus.aux_req = 0;
        end
      end
    end
    bus.cpu_req = 0;
    bus.aux_req = 0;
    chk("cont.count", seen, 4);
    chk("cont.both", both, 0);
    step();

    // Reset in the 2nd ACCESS cycle of a cpu write.
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 20'h00030; bus.cpu_wdata = 16'hCAFE;
    step();
    step();
    chk("abort.pre_we", bus.Mem_WE, 0);
    chk("abort.pre_doe", bus.sram_wdata_oe, 1);
    #3;
    Reset = 1'b1;
    #1;
    chk("abort.we", bus.Mem_WE, 1);
    chk("abort.doe", bus.sram_wdata_oe, 0);
    chk("abort.ce", bus.Mem_CE, 1);
    chk("abort.oe", bus.Mem_OE, 1);
    chk("abort.busy", bus.busy, 0);
    chk("abort.rdata", bus.rdata, 16'h0000);
    chk("abort.saddr", bus.sram_addr, 20'h0);
    bus.cpu_req = 0;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.cpu_done) dones++;
    end
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (bus.cpu_done) dones++;
    end
    chk("abort.nodone", dones, 0);

    // Fresh request after the abort.
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 20'h00010;
    wait_done(1'b0, 1'b0, steps, ce_low);
    bus.cpu_req = 0;
    chk("fresh.latency", steps, 3);
    chk("fresh.ce_cycles", ce_low, 2);
    chk("fresh.rdata", bus.rdata, 16'hBEEF);
    step();

    // ACCESS_CYCLES=3 instance.
    bus3.cpu_req = 1; bus3.cpu_we = 0; bus3.cpu_addr = 20'h00010;
    wait_done(1'b1, 1'b0, steps, ce_low);
    bus3.cpu_req = 0;
    chk("ac3.latency", steps, 4);
    chk("ac3.ce_cycles", ce_low, 3);
    chk("ac3.rdata", bus3.rdata, 16'hBEEF);
    chk("ac3.adone", bus3.aux_done, 0);
    step();
    chk("ac3.idle", bus3.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
